// File: rtl/bus_slave_regfile.sv
// bus_slave_regfile: wait-stated register-file bus slave; define BUS_SLAVE_WR_LOCK_EN to block writes above index 0 while regs[0][0] is set
module bus_slave_regfile #(
  parameter int REG_ADDR_W = 4,
  parameter int DATA_WIDTH = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs_,
  input  logic                  as_,
  input  logic                  rw,
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rdy_
);
  localparam logic ENABLE_ = 1'b0;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic cap_rw;
  logic [REG_ADDR_W-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_data;
  logic [DATA_WIDTH-1:0] regs [2**REG_ADDR_W];
  logic req, abort, go_ack, cur_rw, wr_en;
  logic [REG_ADDR_W-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_data;
  assign req = cs_ == ENABLE_ && as_ == ENABLE_;
  assign abort = !req;
  assign cur_rw = state == IDLE ? rw : cap_rw;
  assign cur_addr = state == IDLE ? addr : cap_addr;
  assign cur_data = state == IDLE ? wr_data : cap_data;
`ifdef BUS_SLAVE_WR_LOCK_EN
  assign wr_en = go_ack && !cur_rw && (cur_addr == '0 || !regs[0][0]);
`else
  assign wr_en = go_ack && !cur_rw;
`endif
  // next state and counter; go_ack marks the edge that enters ACK
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    go_ack = 1'b0;
    if (state == IDLE && req) begin
      cnt_nx = WC;
      state_nx = WC == 4'd0 ? ACK : WAIT;
      go_ack = WC == 4'd0;
    end else if (state == WAIT) begin
      cnt_nx = cnt - 4'd1;
      state_nx = abort ? IDLE : cnt <= 4'd1 ? ACK : WAIT;
      go_ack = !abort && cnt <= 4'd1;
    end else if (state == ACK) begin
      state_nx = IDLE;
    end
  end
  // state, capture and registered bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      cap_rw <= 1'b1;
      cap_addr <= '0;
      cap_data <= '0;
      rdy_ <= ~ENABLE_;
      rd_data <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (state == IDLE) begin
        cap_rw <= rw;
        cap_addr <= addr;
        cap_data <= wr_data;
      end
      rdy_ <= go_ack ? ENABLE_ : ~ENABLE_;
      rd_data <= go_ack && cur_rw ? regs[cur_addr] : '0;
    end
  end
  // register file, written on the edge entering ACK
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**REG_ADDR_W; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[cur_addr] <= cur_data;
    end
  end
endmodule

// File: tb/tb_bus_slave_regfile.sv
// tb_bus_slave_regfile: three slaves (WAIT_CYCLES 1, 0, 3) checked against an array model
module tb_bus_slave_regfile;
  logic clk = 1'b0;
  logic reset;
  logic cs_[3], as_[3], rw[3];
  logic [3:0] addr[3];
  logic [31:0] wr_data[3], rd_data[3];
  logic rdy_[3];
  logic [31:0] mdl[3][16];
  int wc[3] = '{1, 0, 3};
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  bus_slave_regfile #(.WAIT_CYCLES(1)) u0 (.clk(clk), .reset(reset), .cs_(cs_[0]), .as_(as_[0]), .rw(rw[0]),
    .addr(addr[0]), .wr_data(wr_data[0]), .rd_data(rd_data[0]), .rdy_(rdy_[0]));
  bus_slave_regfile #(.WAIT_CYCLES(0)) u1 (.clk(clk), .reset(reset), .cs_(cs_[1]), .as_(as_[1]), .rw(rw[1]),
    .addr(addr[1]), .wr_data(wr_data[1]), .rd_data(rd_data[1]), .rdy_(rdy_[1]));
  bus_slave_regfile #(.WAIT_CYCLES(3)) u2 (.clk(clk), .reset(reset), .cs_(cs_[2]), .as_(as_[2]), .rw(rw[2]),
    .addr(addr[2]), .wr_data(wr_data[2]), .rd_data(rd_data[2]), .rdy_(rdy_[2]));
  function automatic void mdl_clear();
    for (int k = 0; k < 3; k++) for (int a = 0; a < 16; a++) mdl[k][a] = 32'd0;
  endfunction
  function automatic void mdl_write(int k, logic [3:0] a, logic [31:0] d);
`ifdef BUS_SLAVE_WR_LOCK_EN
    if (a == 4'd0 || !mdl[k][0][0]) mdl[k][a] = d;
`else
    mdl[k][a] = d;
`endif
  endfunction
  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      cs_[k] = 1'b1; as_[k] = 1'b1; rw[k] = 1'b1; addr[k] = 4'd0; wr_data[k] = 32'd0;
    end
  endtask
  task automatic txn(input int k, input logic r, input logic [3:0] a, input logic [31:0] d, input string tag);
    logic [31:0] exp;
    exp = r ? mdl[k][a] : 32'd0;
    cs_[k] = 1'b0; as_[k] = 1'b0; rw[k] = r; addr[k] = a; wr_data[k] = d;
    for (int n = 0; n <= wc[k]; n++) begin
      @(negedge clk);
      n_chk++;
      if (n < wc[k]) begin
        if (rdy_[k] !== 1'b1 || rd_data[k] !== 32'd0) begin
          n_fail++;
          $display("FAIL %s wait%0d: rdy_=%b rd_data=%h, required rdy_=1 rd_data=0", tag, n, rdy_[k], rd_data[k]);
        end
      end else begin
        if (rdy_[k] !== 1'b0 || rd_data[k] !== exp) begin
          n_fail++;
          $display("FAIL %s ack: rdy_=%b rd_data=%h, required rdy_=0 rd_data=%h", tag, rdy_[k], rd_data[k], exp);
        end
        cs_[k] = 1'b1; as_[k] = 1'b1;
      end
    end
    if (!r) mdl_write(k, a, d);
    @(negedge clk);
    n_chk++;
    if (rdy_[k] !== 1'b1 || rd_data[k] !== 32'd0) begin
      n_fail++;
      $display("FAIL %s after: rdy_=%b rd_data=%h, required rdy_=1 rd_data=0", tag, rdy_[k], rd_data[k]);
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    idle_all();
    mdl_clear();
    repeat (2) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (rdy_[k] !== 1'b1 || rd_data[k] !== 32'd0) begin
          n_fail++;
          $display("FAIL reset dut%0d: rdy_=%b rd_data=%h, required 1/0", k, rdy_[k], rd_data[k]);
        end
      end
    end
    reset = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 16; a++) txn(0, 1'b1, 4'(a), 32'd0, "reset_rd");
  endtask
  task automatic test_write_read();
    txn(0, 1'b0, 4'd3, 32'hDEADBEEF, "wr3");
    txn(0, 1'b1, 4'd3, 32'd0, "rd3");
  endtask
  task automatic test_back_to_back();
    txn(1, 1'b0, 4'd0, 32'h11111110, "z_wr0");
    txn(1, 1'b0, 4'd1, 32'h22222222, "z_wr1");
    txn(1, 1'b1, 4'd0, 32'd0, "z_rd0");
    txn(1, 1'b1, 4'd1, 32'd0, "z_rd1");
  endtask
  task automatic test_abort();
    cs_[2] = 1'b0; as_[2] = 1'b0; rw[2] = 1'b0; addr[2] = 4'd5; wr_data[2] = 32'h12345678;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (n == 1) begin
        as_[2] = 1'b1; cs_[2] = 1'b1;
      end
      n_chk++;
      if (rdy_[2] !== 1'b1 || rd_data[2] !== 32'd0) begin
        n_fail++;
        $display("FAIL abort cyc%0d: rdy_=%b rd_data=%h, required 1/0", n, rdy_[2], rd_data[2]);
      end
    end
    txn(2, 1'b1, 4'd5, 32'd0, "abort_rd5");
  endtask
  task automatic test_reset_mid();
    txn(2, 1'b0, 4'd7, 32'hCAFEF00D, "rm_wr7");
    cs_[2] = 1'b0; as_[2] = 1'b0; rw[2] = 1'b1; addr[2] = 4'd7;
    @(negedge clk);
    reset = 1'b1;
    cs_[2] = 1'b1; as_[2] = 1'b1;
    mdl_clear();
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      reset = 1'b0;
      n_chk++;
      if (rdy_[2] !== 1'b1 || rd_data[2] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_mid cyc%0d: rdy_=%b rd_data=%h, required 1/0", n, rdy_[2], rd_data[2]);
      end
    end
    txn(2, 1'b1, 4'd7, 32'd0, "rm_rd7");
  endtask
  task automatic test_lock();
    txn(0, 1'b0, 4'd0, 32'd1, "lk_wr0_1");
    txn(0, 1'b0, 4'd2, 32'hAA, "lk_wr2_a");
    txn(0, 1'b1, 4'd2, 32'd0, "lk_rd2_a");
    txn(0, 1'b0, 4'd0, 32'd0, "lk_wr0_0");
    txn(0, 1'b0, 4'd2, 32'hAA, "lk_wr2_b");
    txn(0, 1'b1, 4'd2, 32'd0, "lk_rd2_b");
  endtask
  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      txn(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, "rand");
    end
    for (int k = 0; k < 3; k++) for (int a = 0; a < 16; a++) txn(k, 1'b1, 4'(a), 32'd0, "sweep");
  endtask
  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_lock();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
